// File: rtl/wfq_pkg.sv
// Shared definitions for the WFQ per-flow count table: command encoding,
// control states and default geometry.
package wfq_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_WRITE = 2'b11
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/wfq_count_ram.sv
// Count storage: one write port and two registered, read-first read ports
// (read-modify-write port and scheduler query port).
module wfq_count_ram
  import wfq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [CNT_W-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rmw_addr_i,
  output logic [CNT_W-1:0]  rmw_data_o,
  input  logic [ADDR_W-1:0] qry_addr_i,
  output logic [CNT_W-1:0]  qry_data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] rmw_data_q;
  logic [CNT_W-1:0] qry_data_q;

  // Storage is never reset; the owner clears it with a sweep.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Non-blocking reads of the same array give read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_data_q <= '0;
      qry_data_q <= '0;
    end else begin
      rmw_data_q <= mem_q[rmw_addr_i];
      qry_data_q <= mem_q[qry_addr_i];
    end
  end

  assign rmw_data_o = rmw_data_q;
  assign qry_data_o = qry_data_q;

endmodule

// File: rtl/wfq_count_table.sv
// Per-flow saturating packet counters with a pipelined read-modify-write
// command port, same-flow bypass, self-clearing init sweep and query port.
module wfq_count_table
  import wfq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_data,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [CNT_W-1:0]  rsp_count,
  output logic              rsp_sat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              init_done
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] sweep_q;
  logic              init_done_q;

  logic              s1_valid_q;
  op_e               s1_op_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [CNT_W-1:0]  s1_data_q;

  logic              byp_valid_q;
  logic [ADDR_W-1:0] byp_addr_q;
  logic [CNT_W-1:0]  byp_cnt_q;

  logic              rsp_valid_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [CNT_W-1:0]  rsp_count_q;
  logic              rsp_sat_q;

  logic [CNT_W-1:0]  ram_rmw_data;
  logic [CNT_W-1:0]  old_cnt;
  logic [CNT_W-1:0]  count_d;
  logic              sat_d;
  logic              s1_writes;
  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data;

  assign accept    = cmd_valid && init_done_q;
  assign s1_writes = s1_valid_q && (s1_op_q != OP_READ);

  // The write committed last cycle is not yet visible through the read-first RAM.
  always_comb begin
    old_cnt = ram_rmw_data;
    if (byp_valid_q && (byp_addr_q == s1_addr_q)) begin
      old_cnt = byp_cnt_q;
    end
  end

  always_comb begin
    count_d = old_cnt;
    sat_d   = 1'b0;
    case (s1_op_q)
      OP_READ: count_d = old_cnt;
      OP_INC: begin
        if (old_cnt == CNT_MAX) sat_d = 1'b1;
        else                    count_d = old_cnt + 1'b1;
      end
      OP_DEC: begin
        if (old_cnt == '0) sat_d = 1'b1;
        else               count_d = old_cnt - 1'b1;
      end
      OP_WRITE: count_d = s1_data_q;
      default: count_d = old_cnt;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sweep_q;
    wr_data = '0;
    if (state_q == ST_INIT) begin
      wr_en = 1'b1;
    end else if (s1_writes) begin
      wr_en   = 1'b1;
      wr_addr = s1_addr_q;
      wr_data = count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == LAST_ADDR) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: init_done_q <= 1'b1;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_READ;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      byp_valid_q <= 1'b0;
      byp_addr_q  <= '0;
      byp_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_count_q <= '0;
      rsp_sat_q   <= 1'b0;
    end else begin
      s1_valid_q  <= accept;
      s1_op_q     <= op_e'(cmd_op);
      s1_addr_q   <= cmd_addr;
      s1_data_q   <= cmd_data;
      byp_valid_q <= s1_writes;
      byp_addr_q  <= s1_addr_q;
      byp_cnt_q   <= count_d;
      rsp_valid_q <= s1_valid_q;
      rsp_addr_q  <= s1_addr_q;
      rsp_count_q <= count_d;
      rsp_sat_q   <= s1_valid_q && sat_d;
    end
  end

  wfq_count_ram #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rmw_addr_i(cmd_addr),
    .rmw_data_o(ram_rmw_data),
    .qry_addr_i(rd_addr),
    .qry_data_o(rd_data)
  );

  assign cmd_ready = init_done_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_count = rsp_count_q;
  assign rsp_sat   = rsp_sat_q;

endmodule

// File: doc/wfq_count_table.md
# wfq_count_table

Per-flow packet-count table for the WFQ scheduler. It is the parametrised successor to the plain count RAM: it holds one saturating counter per flow and executes READ/INC/DEC/WRITE commands as a pipelined read-modify-write at one command per cycle. Same-address back-to-back commands are resolved by bypass. After reset it self-clears the whole table with an init sweep. A separate query port gives the scheduler side-band reads of committed counts.

## Interface
Parameters:
- ADDR_W, 13, flow-index width; table depth is 2**ADDR_W.
- CNT_W, 8, counter width; counters saturate at 0 and 2**CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready; equals init_done.
- cmd_op  in  2  00 READ, 01 INC, 10 DEC, 11 WRITE.
- cmd_addr  in  ADDR_W  flow index.
- cmd_data  in  CNT_W  value for WRITE; ignored otherwise.
- rsp_valid  out  1  response strobe, one per accepted command.
- rsp_addr  out  ADDR_W  flow index of the response.
- rsp_count  out  CNT_W  count after the command is applied (the stored value for READ).
- rsp_sat  out  1  INC at max or DEC at 0 (the count is left unchanged).
- rd_addr  in  ADDR_W  query-port address, sampled every cycle.
- rd_data  out  CNT_W  query-port data.
- init_done  out  1  table cleared, block operational.

## Operation
- FSM states: INIT and RUN.
  - INIT is entered on reset. It writes 0 to addresses 0 … 2**ADDR_W-1, one per cycle, in ascending order.
  - After the last address is written, the FSM moves to RUN and init_done rises.
  - cmd_ready is 0 in INIT. Commands presented during INIT are not accepted.
- Pipeline for a command accepted in cycle T:
  - S0 (cycle T): the RAM read is issued at cmd_addr.
  - S1 (cycle T+1): the old value is taken from RAM, or from the bypass (below). The new value is computed and written at the end of T+1.
  - S2 (cycle T+2): rsp_* is registered and valid for one cycle.
- Arithmetic:
  - INC: new = old+1, unless old = 2**CNT_W-1, in which case new = old and sat = 1.
  - DEC: new = old-1, unless old = 0, in which case new = old and sat = 1.
  - WRITE: new = cmd_data, sat = 0.
  - READ: no RAM write, new = old, sat = 0.
- Bypass: the address and value of the last S1 write are held in a register.
  - If the S1 address equals that held write address from the previous cycle, the held value replaces the RAM data.
  - This covers back-to-back commands to the same flow, including long runs of INC on one flow.
- Commands two or more cycles apart need no bypass, because the RAM write has already committed.
- The query port is a RAM read with 1-cycle latency, read-first.
  - A query that coincides with a write to the same address returns the pre-write value.
  - During INIT, rd_data returns whatever the sweep has cleared so far.

## Timing
- Reset values: cmd_ready 0, init_done 0, rsp_valid 0, rsp_addr 0, rsp_count 0, rsp_sat 0, rd_data 0; FSM = INIT; sweep address 0.
- Init lasts exactly 2**ADDR_W cycles after rst deasserts. init_done is high in the following cycle.
- Command to response latency is 2 cycles. Throughput is 1 command per cycle, with no stalls in RUN.
- Reset asserted mid-operation:
  - In-flight commands are dropped with no response.
  - rsp_valid falls immediately.
  - The FSM restarts INIT from address 0.
- Table contents after any reset are all zero. No previous counts survive.

## Structure
- Shared package wfq_pkg:
  - op encoding constants OP_READ, OP_INC, OP_DEC, OP_WRITE;
  - default ADDR_W and CNT_W.
- Sub-module wfq_count_ram:
  - one write port, two registered read ports (RMW port and query port), read-first;
  - no reset on the storage array.
- Top level holds the init FSM, S1/S2 pipeline registers, bypass register and saturation logic.

## Test plan
- Init sweep (ADDR_W=4, CNT_W=4): release rst → init_done rises after 16 cycles. READ of every address → rsp_count 0. cmd_ready stays 0 throughout INIT.
- Back-to-back INC: INC on flow 3 for 5 consecutive cycles → rsp_count 1,2,3,4,5 on consecutive cycles starting 2 cycles after the first INC.
- Saturation:
  - WRITE 15 to flow 7, then INC → rsp_count 15, rsp_sat 1.
  - DEC on a fresh flow 2 → rsp_count 0, rsp_sat 1.
- Interleaved flows: the sequence INC f1, INC f2, DEC f1, INC f1 (consecutive cycles) → responses (f1,1), (f2,1), (f1,0), (f1,1). A query of f1 one cycle after the last write returns 1.
- Query read-first: WRITE 9 to flow 5 with rd_addr=5 in the write-commit cycle → rd_data shows the old value 0, then 9 on the next query.
- Reset mid-run: assert rst while 2 commands are in flight → no rsp_valid afterwards. After re-init, READ flow 3 → 0.
